// File: rtl/el2_ifu_iccm_ctl.sv
// el2_ifu_iccm_ctl: ICCM port arbiter (ECC correction > DMA > fetch) with correction-write sequencer and bounded DMA streak.
module el2_ifu_iccm_ctl #(
    parameter int ICCM_BITS      = 16,
    parameter int DMA_MAX_CONSEC = 4
) (
    input  logic                 clk,
    input  logic                 rst_l,
    input  logic                 fetch_req,
    input  logic [ICCM_BITS-1:1] fetch_addr,
    output logic                 fetch_gnt,
    output logic                 fetch_rvalid,
    input  logic                 dma_req,
    input  logic                 dma_write,
    input  logic [ICCM_BITS-1:1] dma_addr,
    input  logic [2:0]           dma_size,
    input  logic [77:0]          dma_wdata,
    output logic                 dma_gnt,
    output logic                 dma_rvalid,
    input  logic                 ecc_sb_err,
    input  logic [ICCM_BITS-1:1] ecc_err_addr,
    input  logic [38:0]          ecc_corr_data,
    output logic                 iccm_wren,
    output logic                 iccm_rden,
    output logic [ICCM_BITS-1:1] iccm_rw_addr,
    output logic [2:0]           iccm_wr_size,
    output logic [77:0]          iccm_wr_data,
    output logic                 iccm_buf_correct_ecc,
    output logic                 iccm_correction_state,
    output logic                 corr_drop
);
    typedef enum logic [1:0] {IDLE, CWR, CDONE} state_t;
    localparam logic [3:0] MAX = 4'(DMA_MAX_CONSEC);
    state_t               state;
    logic [3:0]           streak;
    logic [ICCM_BITS-1:1] err_addr;
    logic [ICCM_BITS-1:1] last_addr;
    logic [38:0]          corr_data;
    logic                 cwr;
    logic                 dma_win;
    logic                 dma_wr;
    always_comb begin
        cwr                   = state == CWR;
        dma_win               = dma_req && !(fetch_req && streak == MAX);
        dma_gnt               = rst_l && !cwr && dma_win;
        fetch_gnt             = rst_l && !cwr && fetch_req && !dma_win;
        dma_wr                = dma_gnt && dma_write;
        iccm_wren             = cwr || dma_wr;
        iccm_rden             = fetch_gnt || (dma_gnt && !dma_write);
        iccm_rw_addr          = cwr ? err_addr : dma_gnt ? dma_addr : fetch_gnt ? fetch_addr : last_addr;
        iccm_wr_size          = cwr ? 3'b010 : dma_wr ? dma_size : 3'b000;
        iccm_wr_data          = cwr ? {corr_data, corr_data} : dma_wr ? dma_wdata : 78'd0;
        iccm_buf_correct_ecc  = cwr;
        iccm_correction_state = state != IDLE;
    end
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state        <= IDLE;
            streak       <= '0;
            err_addr     <= '0;
            corr_data    <= '0;
            last_addr    <= '0;
            fetch_rvalid <= 1'b0;
            dma_rvalid   <= 1'b0;
            corr_drop    <= 1'b0;
        end else begin
            fetch_rvalid <= fetch_gnt;
            dma_rvalid   <= dma_gnt && !dma_write;
            corr_drop    <= ecc_sb_err && state != IDLE;
            last_addr    <= iccm_rw_addr;
            streak       <= (!fetch_req || fetch_gnt) ? 4'd0 : (dma_gnt && streak != MAX) ? streak + 4'd1 : streak;
            case (state)
                IDLE: if (ecc_sb_err) begin
                    err_addr  <= ecc_err_addr;
                    corr_data <= ecc_corr_data;
                    state     <= CWR;
                end
                CWR:     state <= CDONE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_el2_ifu_iccm_ctl.sv
// tb_el2_ifu_iccm_ctl: directed vector table plus hand sequences for arbitration streaks, correction and reset abort.
module tb_el2_ifu_iccm_ctl;
    logic        clk = 1'b0;
    logic        rst_l = 1'b0;
    logic        fetch_req = 1'b0;
    logic [15:1] fetch_addr = '0;
    logic        fetch_gnt, fetch_rvalid;
    logic        dma_req = 1'b0;
    logic        dma_write = 1'b0;
    logic [15:1] dma_addr = '0;
    logic [2:0]  dma_size = '0;
    logic [77:0] dma_wdata = '0;
    logic        dma_gnt, dma_rvalid;
    logic        ecc_sb_err = 1'b0;
    logic [15:1] ecc_err_addr = '0;
    logic [38:0] ecc_corr_data = '0;
    logic        iccm_wren, iccm_rden;
    logic [15:1] iccm_rw_addr;
    logic [2:0]  iccm_wr_size;
    logic [77:0] iccm_wr_data;
    logic        iccm_buf_correct_ecc, iccm_correction_state, corr_drop;
    int          ntests = 0;
    int          nfail = 0;

    localparam logic [77:0] W1 = {39'h0A_BCDE_F012, 39'h05_5AA5_5AA5};
    localparam logic [77:0] W2 = {39'h7F_0000_FFFF, 39'h00_1111_2222};
    localparam logic [77:0] W3 = {39'h11_1111_1111, 39'h22_2222_2222};
    localparam logic [38:0] D1 = 39'h1_2345_6789;

    el2_ifu_iccm_ctl #(.ICCM_BITS(16), .DMA_MAX_CONSEC(4)) dut (
        .clk(clk), .rst_l(rst_l),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt), .fetch_rvalid(fetch_rvalid),
        .dma_req(dma_req), .dma_write(dma_write), .dma_addr(dma_addr), .dma_size(dma_size),
        .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid),
        .ecc_sb_err(ecc_sb_err), .ecc_err_addr(ecc_err_addr), .ecc_corr_data(ecc_corr_data),
        .iccm_wren(iccm_wren), .iccm_rden(iccm_rden), .iccm_rw_addr(iccm_rw_addr),
        .iccm_wr_size(iccm_wr_size), .iccm_wr_data(iccm_wr_data),
        .iccm_buf_correct_ecc(iccm_buf_correct_ecc), .iccm_correction_state(iccm_correction_state),
        .corr_drop(corr_drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        fr;
        logic [15:1] fa;
        logic        dr;
        logic        dw;
        logic [15:1] da;
        logic [2:0]  ds;
        logic [77:0] wd;
        logic        e_fg;
        logic        e_dg;
        logic        e_wren;
        logic        e_rden;
        logic [15:1] e_addr;
        logic [2:0]  e_size;
        logic [77:0] e_wdata;
        logic        e_frv;
        logic        e_drv;
    } vec_t;

    vec_t tv[10];

    task automatic chk(input string name, input logic [77:0] act, input logic [77:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        fetch_req = 1'b0; dma_req = 1'b0; dma_write = 1'b0; ecc_sb_err = 1'b0;
        dma_size = '0; dma_wdata = '0;
    endtask

    initial begin
        tv[0] = '{1'b0, 15'h0000, 1'b0, 1'b0, 15'h0000, 3'b000, 78'd0, 1'b0, 1'b0, 1'b0, 1'b0, 15'h0040, 3'b000, 78'd0, 1'b0, 1'b1};
        tv[1] = '{1'b1, 15'h0104, 1'b0, 1'b0, 15'h0000, 3'b000, 78'd0, 1'b1, 1'b0, 1'b0, 1'b1, 15'h0104, 3'b000, 78'd0, 1'b0, 1'b0};
        tv[2] = '{1'b0, 15'h0000, 1'b0, 1'b0, 15'h0000, 3'b000, 78'd0, 1'b0, 1'b0, 1'b0, 1'b0, 15'h0104, 3'b000, 78'd0, 1'b1, 1'b0};
        tv[3] = '{1'b0, 15'h0000, 1'b0, 1'b0, 15'h0000, 3'b000, 78'd0, 1'b0, 1'b0, 1'b0, 1'b0, 15'h0104, 3'b000, 78'd0, 1'b0, 1'b0};
        tv[4] = '{1'b0, 15'h0000, 1'b1, 1'b1, 15'h0010, 3'b011, W1,    1'b0, 1'b1, 1'b1, 1'b0, 15'h0010, 3'b011, W1,    1'b0, 1'b0};
        tv[5] = '{1'b0, 15'h0000, 1'b0, 1'b0, 15'h0000, 3'b000, 78'd0, 1'b0, 1'b0, 1'b0, 1'b0, 15'h0010, 3'b000, 78'd0, 1'b0, 1'b0};
        tv[6] = '{1'b0, 15'h0000, 1'b1, 1'b0, 15'h0020, 3'b010, W2,    1'b0, 1'b1, 1'b0, 1'b1, 15'h0020, 3'b000, 78'd0, 1'b0, 1'b0};
        tv[7] = '{1'b0, 15'h0000, 1'b0, 1'b0, 15'h0000, 3'b000, 78'd0, 1'b0, 1'b0, 1'b0, 1'b0, 15'h0020, 3'b000, 78'd0, 1'b0, 1'b1};
        tv[8] = '{1'b0, 15'h0000, 1'b1, 1'b1, 15'h0030, 3'b001, W2,    1'b0, 1'b1, 1'b1, 1'b0, 15'h0030, 3'b001, W2,    1'b0, 1'b0};
        tv[9] = '{1'b0, 15'h0000, 1'b0, 1'b0, 15'h0000, 3'b000, 78'd0, 1'b0, 1'b0, 1'b0, 1'b0, 15'h0030, 3'b000, 78'd0, 1'b0, 1'b0};

        // reset held with both requesters active
        fetch_req = 1'b1; fetch_addr = 15'h0104; dma_req = 1'b1; dma_addr = 15'h0040;
        tick(); tick();
        chk("rst fetch_gnt", fetch_gnt, 0);
        chk("rst dma_gnt", dma_gnt, 0);
        chk("rst wren", iccm_wren, 0);
        chk("rst rden", iccm_rden, 0);
        chk("rst rw_addr", iccm_rw_addr, 0);
        chk("rst wr_data", iccm_wr_data, 0);
        chk("rst rvalids", {fetch_rvalid, dma_rvalid}, 0);
        chk("rst corr", {iccm_buf_correct_ecc, iccm_correction_state, corr_drop}, 0);
        rst_l = 1'b1;
        #1;
        chk("post-rst dma_gnt", dma_gnt, 1);
        chk("post-rst fetch_gnt", fetch_gnt, 0);
        chk("post-rst rw_addr", iccm_rw_addr, 15'h0040);

        for (int i = 0; i < 10; i++) begin
            tick();
            fetch_req = tv[i].fr; fetch_addr = tv[i].fa; dma_req = tv[i].dr; dma_write = tv[i].dw;
            dma_addr = tv[i].da; dma_size = tv[i].ds; dma_wdata = tv[i].wd; ecc_sb_err = 1'b0;
            #3;
            chk($sformatf("v%0d fetch_gnt", i), fetch_gnt, tv[i].e_fg);
            chk($sformatf("v%0d dma_gnt", i), dma_gnt, tv[i].e_dg);
            chk($sformatf("v%0d wren", i), iccm_wren, tv[i].e_wren);
            chk($sformatf("v%0d rden", i), iccm_rden, tv[i].e_rden);
            chk($sformatf("v%0d rw_addr", i), iccm_rw_addr, tv[i].e_addr);
            chk($sformatf("v%0d wr_size", i), iccm_wr_size, tv[i].e_size);
            chk($sformatf("v%0d wr_data", i), iccm_wr_data, tv[i].e_wdata);
            chk($sformatf("v%0d fetch_rvalid", i), fetch_rvalid, tv[i].e_frv);
            chk($sformatf("v%0d dma_rvalid", i), dma_rvalid, tv[i].e_drv);
        end

        // streak bound: D,D,D,D,F repeating
        for (int i = 0; i < 10; i++) begin
            tick();
            fetch_req = 1'b1; fetch_addr = 15'h0070; dma_req = 1'b1; dma_write = 1'b0; dma_addr = 15'h0060;
            #3;
            chk($sformatf("arb%0d fetch_gnt", i), fetch_gnt, (i % 5) == 4);
            chk($sformatf("arb%0d dma_gnt", i), dma_gnt, (i % 5) != 4);
            chk($sformatf("arb%0d rw_addr", i), iccm_rw_addr, ((i % 5) == 4) ? 15'h0070 : 15'h0060);
        end
        tick(); idle_inputs(); #3;
        chk("arb fetch_rvalid", fetch_rvalid, 1);

        // error coincident with DMA write to the same word
        tick();
        dma_req = 1'b1; dma_write = 1'b1; dma_addr = 15'h0208; dma_size = 3'b010; dma_wdata = W3;
        ecc_sb_err = 1'b1; ecc_err_addr = 15'h0208; ecc_corr_data = D1;
        #3;
        chk("capt dma_gnt", dma_gnt, 1);
        chk("capt wr_data", iccm_wr_data, W3);
        chk("capt corr_state", iccm_correction_state, 0);
        // correction write cycle; a second error is dropped
        tick();
        dma_write = 1'b0; dma_addr = 15'h0050; fetch_req = 1'b1; fetch_addr = 15'h0070;
        ecc_err_addr = 15'h0300; ecc_corr_data = 39'h7_0000_0001;
        #3;
        chk("cwr wren", iccm_wren, 1);
        chk("cwr rden", iccm_rden, 0);
        chk("cwr buf_correct_ecc", iccm_buf_correct_ecc, 1);
        chk("cwr corr_state", iccm_correction_state, 1);
        chk("cwr rw_addr", iccm_rw_addr, 15'h0208);
        chk("cwr wr_size", iccm_wr_size, 3'b010);
        chk("cwr wr_data", iccm_wr_data, {D1, D1});
        chk("cwr grants", {fetch_gnt, dma_gnt}, 0);
        chk("cwr corr_drop", corr_drop, 0);
        tick();
        ecc_sb_err = 1'b0;
        #3;
        chk("cdone corr_state", iccm_correction_state, 1);
        chk("cdone buf_correct_ecc", iccm_buf_correct_ecc, 0);
        chk("cdone corr_drop", corr_drop, 1);
        chk("cdone dma_gnt", dma_gnt, 1);
        chk("cdone fetch_gnt", fetch_gnt, 0);
        chk("cdone rw_addr", iccm_rw_addr, 15'h0050);
        tick(); idle_inputs(); #3;
        chk("after corr_state", iccm_correction_state, 0);
        chk("after corr_drop", corr_drop, 0);
        chk("after dma_rvalid", dma_rvalid, 1);
        chk("after rw_addr hold", iccm_rw_addr, 15'h0050);
        tick(); #3;
        chk("no 2nd corr wren", iccm_wren, 0);

        // reset during the correction write aborts it without retry
        tick();
        ecc_sb_err = 1'b1; ecc_err_addr = 15'h0111; ecc_corr_data = 39'h5;
        #3;
        tick();
        ecc_sb_err = 1'b0;
        #1;
        chk("abort pre wren", iccm_wren, 1);
        chk("abort pre rw_addr", iccm_rw_addr, 15'h0111);
        rst_l = 1'b0;
        #1;
        chk("abort wren", iccm_wren, 0);
        chk("abort corr_state", iccm_correction_state, 0);
        tick();
        rst_l = 1'b1;
        #2;
        chk("abort rel wren", iccm_wren, 0);
        tick(); #3;
        chk("abort no retry wren", iccm_wren, 0);
        chk("abort no retry corr_state", iccm_correction_state, 0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule

// File: doc/el2_ifu_iccm_ctl.md
Name: el2_ifu_iccm_ctl

Overview:
Sequencer and arbiter in front of the ICCM bank array. Each cycle it selects one of three requesters and drives the array's single read/write port:
- single-bit-error correction writeback (highest priority)
- DMA read/write
- IFU fetch read (lowest priority)

It also generates the correction-cycle controls used by the array's redundant-row logic, and bounds DMA back-pressure on fetch.

Parameters:
ICCM_BITS, 16, ICCM byte-address width; addresses carry bits [ICCM_BITS-1:1].
DMA_MAX_CONSEC, 4, maximum consecutive DMA grants while fetch is requesting; range 1..15.

Ports:
clk  in  1  clock (active core clock)
rst_l  in  1  reset
fetch_req  in  1  fetch read request
fetch_addr  in  ICCM_BITS-1  fetch halfword address
fetch_gnt  out  1  fetch granted this cycle
fetch_rvalid  out  1  read data for granted fetch valid
dma_req  in  1  DMA request
dma_write  in  1  1=write, 0=read
dma_addr  in  ICCM_BITS-1  DMA address
dma_size  in  3  2'b10 word, 2'b11 dword (bits [1:0])
dma_wdata  in  78  ECC-encoded write data {hi39,lo39}
dma_gnt  out  1  DMA granted this cycle
dma_rvalid  out  1  read data for granted DMA read valid
ecc_sb_err  in  1  single-bit error pulse on a fetch read
ecc_err_addr  in  ICCM_BITS-1  address of erroneous word
ecc_corr_data  in  39  corrected word plus ECC
iccm_wren  out  1  array write enable
iccm_rden  out  1  array read enable
iccm_rw_addr  out  ICCM_BITS-1  array address
iccm_wr_size  out  3  array write size
iccm_wr_data  out  78  array write data
iccm_buf_correct_ecc  out  1  correction write cycle
iccm_correction_state  out  1  correction sequence in progress
corr_drop  out  1  pulse: error report dropped while busy

Behaviour:
Reset:
- rst_l is asynchronous, active-low.
- On reset: FSM to IDLE, DMA streak counter to 0, all registered outputs to 0.

Interface timing:
- Array controls (wren, rden, rw_addr, wr_size, wr_data) are combinational from the current-cycle grant; the array samples them at the next edge.
- fetch_rvalid and dma_rvalid are flops: each asserts exactly one cycle after its granted read.

Correction FSM: IDLE -> CWR -> CDONE -> IDLE.
- IDLE:
  - ecc_sb_err=1 captures ecc_err_addr and ecc_corr_data into registers; next state CWR.
  - No grants are suppressed in the cycle the error is captured.
- CWR:
  - Drives iccm_wren=1, iccm_buf_correct_ecc=1, iccm_correction_state=1.
  - Address = captured address; wr_size=3'b010; wr_data={corr,corr} (splat on both legs).
  - fetch_gnt=0 and dma_gnt=0. Next state CDONE.
- CDONE:
  - iccm_correction_state=1; normal arbitration resumes.
  - Next state IDLE.
- ecc_sb_err outside IDLE is ignored and produces a one-cycle corr_drop pulse. The captured registers are unchanged.

Arbitration (IDLE and CDONE):
- DMA wins over fetch, unless the streak counter equals DMA_MAX_CONSEC and fetch_req=1; then fetch wins.
- Streak counter:
  - increments on each dma_gnt while fetch_req=1, saturating at DMA_MAX_CONSEC;
  - clears on fetch_gnt, or on any cycle with fetch_req=0.
- At most one grant per cycle; wren and rden are never both 1.
- DMA write: wren=1, address/size/data passed through unchanged. dma_size[1:0] values other than 2'b10 and 2'b11 are still passed through.
- DMA read or fetch: rden=1; wr_data and wr_size drive 0.
- With no grant: wren=0, rden=0, rw_addr holds its last value (avoids toggle).

Boundary and simultaneous events:
- dma_req and fetch_req held across a CWR cycle are served in CDONE.
- ecc_sb_err coinciding with a DMA write to the same word: the DMA write proceeds this cycle; the correction writes next cycle (the correction data wins).
- Reset asserted mid-CWR aborts the write; no retry.

Test Plan:
1. Reset with all requests high -> all outputs 0; first cycle after release, dma_gnt=1 and fetch_gnt=0.
2. fetch_req=1, fetch_addr=0x0104 -> rden=1, rw_addr=0x0104, fetch_gnt=1; fetch_rvalid=1 next cycle only.
3. dma_req and fetch_req both held high, DMA_MAX_CONSEC=4 -> grant pattern D,D,D,D,F repeating.
4. ecc_sb_err with addr=0x0208, data=39'h1_2345_6789 -> next cycle wren=1, buf_correct_ecc=1, wr_size=3'b010, wr_data={data,data}, no grants; correction_state=1 for 2 cycles.
5. Second ecc_sb_err during CWR -> corr_drop=1 for one cycle; the write still uses the first address.
6. DMA dword write at 0x0010 -> wren=1, wr_size=3'b011, wr_data=dma_wdata; dma_rvalid stays 0.
